// File: rtl/escalonador_cdb_if.sv
// Bundle of the CDB scheduler's requester, issue, register-query, broadcast and write-back signals.
interface escalonador_cdb_if #(
    parameter int NREQ = 3,
    parameter int LARG = 16
);
    logic [NREQ-1:0] req;
    logic [2:0]      tag0, tag1, tag2;
    logic [LARG-1:0] dado0, dado1, dado2;
    logic [NREQ-1:0] conc;
    logic            emite_valido;
    logic [2:0]      emite_rd, emite_tag;
    logic [2:0]      le_reg1, le_reg2;
    logic [2:0]      qi1, qi2;
    logic            cdb_valido;
    logic [2:0]      cdb_tag;
    logic [LARG-1:0] cdb_dado;
    logic            escr_hab;
    logic [2:0]      escr_reg;
    logic [LARG-1:0] escr_dado;

    modport master (
        output req, tag0, tag1, tag2, dado0, dado1, dado2,
        output emite_valido, emite_rd, emite_tag, le_reg1, le_reg2,
        input  conc, qi1, qi2, cdb_valido, cdb_tag, cdb_dado,
        input  escr_hab, escr_reg, escr_dado
    );

    modport slave (
        input  req, tag0, tag1, tag2, dado0, dado1, dado2,
        input  emite_valido, emite_rd, emite_tag, le_reg1, le_reg2,
        output conc, qi1, qi2, cdb_valido, cdb_tag, cdb_dado,
        output escr_hab, escr_reg, escr_dado
    );
endinterface

// File: rtl/escalonador_cdb.sv
// Round-robin CDB arbiter with registered broadcast, per-register producer-tag table (Qi)
// and a register-bank write port gated by tag ownership.
module escalonador_cdb #(
    parameter int NREQ = 3,
    parameter int LARG = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    escalonador_cdb_if.slave bus
);
    localparam int NREG = 8;

    logic [NREQ-1:0][2:0]      tags;
    logic [NREQ-1:0][LARG-1:0] dados;
    logic [1:0]                p, p_next, win;
    logic                      grant;
    logic [NREG-1:0][2:0]      qi_tab;
    logic [NREG-1:0]           match;
    logic                      cdb_v;
    logic [2:0]                cdb_t;
    logic [LARG-1:0]           cdb_d;
    logic [2:0]                wreg;

    assign tags  = {bus.tag2, bus.tag1, bus.tag0};
    assign dados = {bus.dado2, bus.dado1, bus.dado0};

    // Search starts at the pointer and wraps, so the last winner has lowest priority next.
    always_comb begin
        logic [2:0] j;
        grant  = 1'b0;
        win    = '0;
        bus.conc = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = 3'(p) + 3'(k);
            if (j >= 3'(NREQ)) j = j - 3'(NREQ);
            if (!grant && bus.req[j[1:0]]) begin
                grant = 1'b1;
                win   = j[1:0];
            end
        end
        if (grant) bus.conc[win] = 1'b1;
        p_next = p;
        if (grant) p_next = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
    end

    for (genvar r = 0; r < NREG; r++) begin : g_match
        assign match[r] = cdb_v && (cdb_t != 3'd0) && (qi_tab[r] == cdb_t);
    end

    always_comb begin
        wreg = '0;
        for (int r = 0; r < NREG; r++)
            if (match[r]) wreg = 3'(r);
    end

    assign bus.cdb_valido = cdb_v;
    assign bus.cdb_tag    = cdb_t;
    assign bus.cdb_dado   = cdb_d;
    assign bus.escr_hab   = |match;
    assign bus.escr_reg   = wreg;
    assign bus.escr_dado  = cdb_d;

    // Bypass: a register being written back this cycle already reads as ready.
    assign bus.qi1 = match[bus.le_reg1] ? 3'd0 : qi_tab[bus.le_reg1];
    assign bus.qi2 = match[bus.le_reg2] ? 3'd0 : qi_tab[bus.le_reg2];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            p      <= '0;
            cdb_v  <= 1'b0;
            cdb_t  <= '0;
            cdb_d  <= '0;
            qi_tab <= '0;
        end else begin
            p     <= p_next;
            cdb_v <= |bus.req;
            if (grant) begin
                cdb_t <= tags[win];
                cdb_d <= dados[win];
            end
            for (int r = 0; r < NREG; r++)
                if (match[r]) qi_tab[r] <= 3'd0;
            // Later assignment lets a new issue override the clear of the same register.
            if (bus.emite_valido && bus.emite_tag != 3'd0)
                qi_tab[bus.emite_rd] <= bus.emite_tag;
        end
    end
endmodule
